// File: rtl/icache_line_fill_pkg.sv
// Shared types and default geometry for the instruction-cache line-fill engine.
package my_pkg;

  localparam int ICACHE_WORDS_PER_LINE = 4;
  localparam int IMEM_LAT              = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } fill_state_e;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_line_fill_counter.sv
// Generic up-counter with synchronous clear (priority over enable) and async active-low reset.
module up_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/icache_line_fill.sv
// Fetches one cache line from instruction memory word by word after a miss,
// writing each word into the data array and finally the tag/valid entry.
module icache_line_fill
  import my_pkg::*;
#(
  parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
  parameter int MEM_LAT        = IMEM_LAT,
  localparam int IDX_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             miss_req,
  input  logic [31:0]      miss_addr,
  input  logic             flush,
  output logic             mem_csb,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic             cache_we_n,
  output logic [IDX_W-1:0] cache_widx,
  output logic [31:0]      cache_wdata,
  output logic             cache_tag_we,
  output logic             fill_busy,
  output logic             fill_done
);

  localparam int OFF_W = IDX_W + 2;
  localparam int LAT_W = cnt_width(MEM_LAT);
  localparam logic [31:0]      OFF_MASK = (32'd1 << OFF_W) - 32'd1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

  fill_state_e      state;
  logic [31:0]      line_base;
  logic [IDX_W-1:0] idx;
  logic [LAT_W-1:0] lat;
  logic             idx_clr;
  logic             idx_en;
  logic             lat_clr;
  logic             lat_en;

  // The index saturates at the last word so the address never leaves the line.
  assign idx_clr = flush || (state == IDLE) || (state == DONE);
  assign idx_en  = (state == WRITE) && (idx != LAST_IDX);
  assign lat_clr = flush || (state != WAIT);
  assign lat_en  = (state == WAIT);

  up_counter #(.WIDTH(IDX_W)) u_idx_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (idx_clr),
    .en    (idx_en),
    .count (idx)
  );

  up_counter #(.WIDTH(LAT_W)) u_lat_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (lat_clr),
    .en    (lat_en),
    .count (lat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      line_base <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            line_base <= miss_addr & ~OFF_MASK;
            state     <= ISSUE;
          end
        end
        ISSUE:   state <= (MEM_LAT > 1) ? WAIT : WRITE;
        WAIT:    if (lat == LAT_LAST) state <= WRITE;
        WRITE:   state <= (idx == LAST_IDX) ? DONE : ISSUE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are suppressed in a flush cycle so an aborted fill leaves no side effects.
  assign fill_busy    = (state != IDLE);
  assign mem_csb      = !((state == ISSUE) && !flush);
  assign mem_addr     = line_base | (32'(idx) << 2);
  assign cache_we_n   = !((state == WRITE) && !flush);
  assign cache_widx   = idx;
  assign cache_wdata  = mem_rdata;
  assign cache_tag_we = (state == DONE) && !flush;
  assign fill_done    = cache_tag_we;

endmodule

// File: doc/icache_line_fill.md
ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

Interface
REQ-001 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per cache line (power of two, 2..16).
REQ-002 SHALL have parameter MEM_LAT, default 2, cycles from the mem_csb-low cycle to mem_rdata valid (1..8).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port miss_req  input  1  level; the cache has missed on miss_addr.
REQ-006 SHALL have port miss_addr  input  32  byte address of the missing instruction.
REQ-007 SHALL have port flush  input  1  abort the fill (branch redirect).
REQ-008 SHALL have port mem_csb  output  1  instruction-memory chip select, active-low.
REQ-009 SHALL have port mem_addr  output  32  instruction-memory word byte-address.
REQ-010 SHALL have port mem_rdata  input  32  instruction-memory read data.
REQ-011 SHALL have port cache_we_n  output  1  cache data-array write enable, active-low.
REQ-012 SHALL have port cache_widx  output  log2(WORDS_PER_LINE)  word index within the line.
REQ-013 SHALL have port cache_wdata  output  32  word written to the cache.
REQ-014 SHALL have port cache_tag_we  output  1  one-cycle tag/valid write for the filled line.
REQ-015 SHALL have port fill_busy  output  1  high whenever state is not IDLE; drives the PC stall.
REQ-016 SHALL have port fill_done  output  1  one-cycle pulse on successful completion.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-018 IDLE: miss_req=1 and flush=0 -> latch line base (miss_addr with low log2(WORDS_PER_LINE)+2 bits cleared), clear word index, go ISSUE; otherwise stay.
REQ-019 ISSUE: mem_csb=0, mem_addr=base+4*index for exactly one cycle; next WAIT if MEM_LAT>1, else WRITE.
REQ-020 WAIT: mem_csb=1; a latency counter holds the state for MEM_LAT-1 cycles, then WRITE.
REQ-021 WRITE: cache_we_n=0, cache_widx=index, cache_wdata=mem_rdata (combinational pass-through); next ISSUE with index+1, or DONE if index=WORDS_PER_LINE-1.
REQ-022 DONE: cache_tag_we=1 and fill_done=1 for one cycle; next IDLE unconditionally.
REQ-023 Per-word cost SHALL be 1+MEM_LAT cycles; fill_done SHALL occur WORDS_PER_LINE*(1+MEM_LAT)+1 cycles after the cycle in which miss_req is sampled in IDLE.
REQ-024 Word index SHALL never wrap; the address increment SHALL stay within the latched line (no carry into bits above the line offset).
REQ-025 flush=1 in any non-IDLE state SHALL force IDLE next cycle; in that cycle cache_we_n=1, cache_tag_we=0, fill_done=0; an in-flight read is discarded.
REQ-026 flush and miss_req both high in IDLE: flush wins, stay IDLE.
REQ-027 miss_req and miss_addr changes while fill_busy=1 SHALL be ignored.
REQ-028 Outside ISSUE, mem_csb=1; outside WRITE, cache_we_n=1; outside DONE, cache_tag_we=0 and fill_done=0.

Reset
REQ-029 rstn low SHALL immediately force IDLE, index and latency counter 0, line base 0.
REQ-030 During and after reset: mem_csb=1, cache_we_n=1, cache_tag_we=0, fill_done=0, fill_busy=0, mem_addr=0, cache_widx=0.
REQ-031 Reset mid-fill SHALL abandon the fill with no partial tag write.

Structure
REQ-032 The state enum (fill_state_e) and the defaults ICACHE_WORDS_PER_LINE and IMEM_LAT SHALL live in my_pkg.
REQ-033 The word index and latency counters SHALL each be an instance of one sub-module, up_counter (sync clear, enable, async active-low reset).

Verification
REQ-034 Defaults, miss_addr=0x0000_104C, memory returns addr^0xA5A5_A5A5 -> writes at idx 0..3 from 0x1040/44/48/4C with matching data, fill_done 13 cycles after request.
REQ-035 MEM_LAT=1 -> no WAIT state visited, fill_done 9 cycles after request.
REQ-036 flush asserted during WAIT of word 2 -> IDLE next cycle, no tag write, no fill_done; a new miss to 0x2000 then completes normally.
REQ-037 miss_req held high through a fill, miss_addr changed mid-fill -> original line completes; re-fill starts in the cycle after DONE.
REQ-038 rstn pulled low during WRITE of word 1 -> outputs at reset values immediately, fill_busy=0, no cache_tag_we.
REQ-039 miss_req and flush high together in IDLE -> stays IDLE, mem_csb stays 1.
